// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/bubble sequencer for the five-stage pipeline
module pipeline_hazard_controller #(
  parameter int REG_ADD_WIDTH    = 5,
  parameter int D_CACHE_LW_WIDTH = 3,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [REG_ADD_WIDTH-1:0]    ID_RS1_ADDRESS,
  input  logic [REG_ADD_WIDTH-1:0]    ID_RS2_ADDRESS,
  input  logic                        ID_RS1_USED,
  input  logic                        ID_RS2_USED,
  input  logic [REG_ADD_WIDTH-1:0]    EX_RD_ADDRESS,
  input  logic                        EX_RD_WRITE_ENABLE,
  input  logic [D_CACHE_LW_WIDTH-1:0] EX_DATA_CACHE_LOAD,
  input  logic                        EX_MULDIV_VALID,
  input  logic                        BRANCH_TAKEN,
  input  logic                        I_CACHE_READY,
  input  logic                        MEM_ACCESS_VALID,
  input  logic                        D_CACHE_READY,
  input  logic                        MULDIV_DONE,
  output logic                        MULDIV_START,
  output logic                        STALL_PROGRAM_COUNTER,
  output logic                        STALL_INSTRUCTION_FETCH,
  output logic                        STALL_INSTRUCTION_DECODE,
  output logic                        STALL_EXECUTION_STAGE,
  output logic                        STALL_DATA_MEMORY,
  output logic                        FLUSH_INSTRUCTION_FETCH,
  output logic                        FLUSH_INSTRUCTION_DECODE,
  output logic                        BUBBLE_MEMORY_STAGE,
  output logic [COUNT_WIDTH-1:0]      STALL_CYCLES
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } md_state_t;

  md_state_t              r_state;
  md_state_t              w_state_next;
  logic [COUNT_WIDTH-1:0] r_stall_cycles;

  logic w_dmiss;
  logic w_rs1_match;
  logic w_rs2_match;
  logic w_load_use;
  logic w_md_wait;
  logic w_md_start;
  logic w_stall_ex;
  logic w_stall_id;
  logic w_stall_if;
  logic w_branch;

  // Hazard terms derived from the current-cycle datapath inputs.
  always_comb begin
    w_dmiss     = MEM_ACCESS_VALID & ~D_CACHE_READY;
    w_rs1_match = ID_RS1_USED & (ID_RS1_ADDRESS == EX_RD_ADDRESS);
    w_rs2_match = ID_RS2_USED & (ID_RS2_ADDRESS == EX_RD_ADDRESS);
    w_load_use  = (EX_DATA_CACHE_LOAD != '0) & EX_RD_WRITE_ENABLE &
                  (EX_RD_ADDRESS != '0) & (w_rs1_match | w_rs2_match);
  end

  // Mul/div sequencer next state; START depends only on state, valid and dmiss.
  always_comb begin
    w_state_next = r_state;
    w_md_start   = 1'b0;
    w_md_wait    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The start cycle itself holds EX; a D-miss defers the start.
        w_md_wait = EX_MULDIV_VALID;
        if (EX_MULDIV_VALID && !w_dmiss) begin
          w_md_start   = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // EX captures the result in the DONE cycle unless MEM is missing.
        w_md_wait = ~(MULDIV_DONE & ~w_dmiss);
        if (MULDIV_DONE) begin
          w_state_next = w_dmiss ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Result is parked in the unit until MEM lets the pipeline move.
        w_md_wait = w_dmiss;
        if (!w_dmiss) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Stall chain from the back of the pipe forward, with taken-branch override.
  always_comb begin
    w_stall_ex = w_dmiss | w_md_wait;
    w_stall_id = w_stall_ex | w_load_use;
    w_stall_if = w_stall_id | ~I_CACHE_READY;
    w_branch   = BRANCH_TAKEN & ~w_stall_ex;
  end

  // Output mux: reset forces everything held/flushed, then branch beats load-use and I-miss.
  always_comb begin
    MULDIV_START             = w_md_start;
    STALL_DATA_MEMORY        = w_dmiss;
    STALL_EXECUTION_STAGE    = w_stall_ex;
    STALL_INSTRUCTION_DECODE = w_stall_id;
    STALL_INSTRUCTION_FETCH  = w_stall_if;
    STALL_PROGRAM_COUNTER    = w_stall_if;
    BUBBLE_MEMORY_STAGE      = w_stall_ex & ~w_dmiss;
    FLUSH_INSTRUCTION_DECODE = w_load_use & ~w_stall_ex;
    FLUSH_INSTRUCTION_FETCH  = ~I_CACHE_READY & ~w_stall_id;
    if (w_branch) begin
      // Younger instructions are dead; let the PC load the target.
      FLUSH_INSTRUCTION_FETCH  = 1'b1;
      FLUSH_INSTRUCTION_DECODE = 1'b1;
      STALL_PROGRAM_COUNTER    = 1'b0;
      STALL_INSTRUCTION_FETCH  = 1'b0;
      STALL_INSTRUCTION_DECODE = 1'b0;
    end
    if (!RESET_N) begin
      MULDIV_START             = 1'b0;
      STALL_DATA_MEMORY        = 1'b1;
      STALL_EXECUTION_STAGE    = 1'b1;
      STALL_INSTRUCTION_DECODE = 1'b1;
      STALL_INSTRUCTION_FETCH  = 1'b1;
      STALL_PROGRAM_COUNTER    = 1'b1;
      BUBBLE_MEMORY_STAGE      = 1'b1;
      FLUSH_INSTRUCTION_DECODE = 1'b1;
      FLUSH_INSTRUCTION_FETCH  = 1'b1;
    end
  end

  // Mul/div state register; reset abandons any operation in flight.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Front-end stall counter, wrapping naturally at its width.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_stall_cycles <= '0;
    end else if (STALL_PROGRAM_COUNTER) begin
      r_stall_cycles <= r_stall_cycles + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign STALL_CYCLES = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed checks for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [4:0] ID_RS1_ADDRESS, ID_RS2_ADDRESS, EX_RD_ADDRESS;
  logic       ID_RS1_USED, ID_RS2_USED, EX_RD_WRITE_ENABLE;
  logic [2:0] EX_DATA_CACHE_LOAD;
  logic       EX_MULDIV_VALID, BRANCH_TAKEN, I_CACHE_READY;
  logic       MEM_ACCESS_VALID, D_CACHE_READY, MULDIV_DONE;

  logic        MULDIV_START, STALL_PROGRAM_COUNTER, STALL_INSTRUCTION_FETCH;
  logic        STALL_INSTRUCTION_DECODE, STALL_EXECUTION_STAGE, STALL_DATA_MEMORY;
  logic        FLUSH_INSTRUCTION_FETCH, FLUSH_INSTRUCTION_DECODE, BUBBLE_MEMORY_STAGE;
  logic [31:0] STALL_CYCLES;

  logic       w4_start, w4_spc, w4_sif, w4_sid, w4_sex, w4_smem, w4_fif, w4_fid, w4_bub;
  logic [3:0] w4_cycles;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_controller dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .ID_RS1_ADDRESS(ID_RS1_ADDRESS), .ID_RS2_ADDRESS(ID_RS2_ADDRESS),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .EX_RD_ADDRESS(EX_RD_ADDRESS), .EX_RD_WRITE_ENABLE(EX_RD_WRITE_ENABLE),
    .EX_DATA_CACHE_LOAD(EX_DATA_CACHE_LOAD), .EX_MULDIV_VALID(EX_MULDIV_VALID),
    .BRANCH_TAKEN(BRANCH_TAKEN), .I_CACHE_READY(I_CACHE_READY),
    .MEM_ACCESS_VALID(MEM_ACCESS_VALID), .D_CACHE_READY(D_CACHE_READY),
    .MULDIV_DONE(MULDIV_DONE), .MULDIV_START(MULDIV_START),
    .STALL_PROGRAM_COUNTER(STALL_PROGRAM_COUNTER),
    .STALL_INSTRUCTION_FETCH(STALL_INSTRUCTION_FETCH),
    .STALL_INSTRUCTION_DECODE(STALL_INSTRUCTION_DECODE),
    .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE),
    .STALL_DATA_MEMORY(STALL_DATA_MEMORY),
    .FLUSH_INSTRUCTION_FETCH(FLUSH_INSTRUCTION_FETCH),
    .FLUSH_INSTRUCTION_DECODE(FLUSH_INSTRUCTION_DECODE),
    .BUBBLE_MEMORY_STAGE(BUBBLE_MEMORY_STAGE), .STALL_CYCLES(STALL_CYCLES)
  );

  pipeline_hazard_controller #(.COUNT_WIDTH(4)) dut_w4 (
    .CLK(CLK), .RESET_N(RESET_N),
    .ID_RS1_ADDRESS(ID_RS1_ADDRESS), .ID_RS2_ADDRESS(ID_RS2_ADDRESS),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .EX_RD_ADDRESS(EX_RD_ADDRESS), .EX_RD_WRITE_ENABLE(EX_RD_WRITE_ENABLE),
    .EX_DATA_CACHE_LOAD(EX_DATA_CACHE_LOAD), .EX_MULDIV_VALID(EX_MULDIV_VALID),
    .BRANCH_TAKEN(BRANCH_TAKEN), .I_CACHE_READY(I_CACHE_READY),
    .MEM_ACCESS_VALID(MEM_ACCESS_VALID), .D_CACHE_READY(D_CACHE_READY),
    .MULDIV_DONE(MULDIV_DONE), .MULDIV_START(w4_start),
    .STALL_PROGRAM_COUNTER(w4_spc), .STALL_INSTRUCTION_FETCH(w4_sif),
    .STALL_INSTRUCTION_DECODE(w4_sid), .STALL_EXECUTION_STAGE(w4_sex),
    .STALL_DATA_MEMORY(w4_smem), .FLUSH_INSTRUCTION_FETCH(w4_fif),
    .FLUSH_INSTRUCTION_DECODE(w4_fid), .BUBBLE_MEMORY_STAGE(w4_bub),
    .STALL_CYCLES(w4_cycles)
  );

  // {SPC, SIF, SID, SEX, SMEM, FIF, FID, BUB, START}
  logic [8:0] ctl;
  assign ctl = {STALL_PROGRAM_COUNTER, STALL_INSTRUCTION_FETCH, STALL_INSTRUCTION_DECODE,
                STALL_EXECUTION_STAGE, STALL_DATA_MEMORY, FLUSH_INSTRUCTION_FETCH,
                FLUSH_INSTRUCTION_DECODE, BUBBLE_MEMORY_STAGE, MULDIV_START};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [8:0] expv);
    #1;
    chk(tag, {23'd0, ctl}, {23'd0, expv});
  endtask

  task automatic tick(input bit spc);
    @(posedge CLK);
    if (spc && RESET_N) exp_cnt++;
    #1;
  endtask

  task automatic idle_inputs();
    ID_RS1_ADDRESS = 5'd0; ID_RS2_ADDRESS = 5'd0; EX_RD_ADDRESS = 5'd0;
    ID_RS1_USED = 1'b0; ID_RS2_USED = 1'b0; EX_RD_WRITE_ENABLE = 1'b0;
    EX_DATA_CACHE_LOAD = 3'd0; EX_MULDIV_VALID = 1'b0; BRANCH_TAKEN = 1'b0;
    I_CACHE_READY = 1'b1; MEM_ACCESS_VALID = 1'b0; D_CACHE_READY = 1'b1;
    MULDIV_DONE = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    EX_DATA_CACHE_LOAD = 3'b010; EX_RD_ADDRESS = rd; EX_RD_WRITE_ENABLE = 1'b1;
    ID_RS2_ADDRESS = rd; ID_RS2_USED = 1'b1;
  endtask

  initial begin
    // Reset with random inputs for three cycles
    idle_inputs();
    RESET_N = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      {ID_RS1_ADDRESS, ID_RS2_ADDRESS, EX_RD_ADDRESS} = 15'($urandom);
      {ID_RS1_USED, ID_RS2_USED, EX_RD_WRITE_ENABLE, EX_DATA_CACHE_LOAD} = 6'($urandom);
      {EX_MULDIV_VALID, BRANCH_TAKEN, I_CACHE_READY} = 3'($urandom);
      {MEM_ACCESS_VALID, D_CACHE_READY, MULDIV_DONE} = 3'($urandom);
      chk_ctl("reset_outputs", 9'b111111110);
      tick(0);
    end
    idle_inputs();
    RESET_N = 1'b1;
    chk_ctl("post_reset_idle", 9'b000000000);
    chk("post_reset_count", STALL_CYCLES, 32'd0);
    tick(0);

    // Load-use on rs2: one bubble, then the pipe flows
    set_load_use(5'd5);
    chk_ctl("load_use_stall", 9'b111000100);
    tick(1);
    EX_DATA_CACHE_LOAD = 3'd0; EX_RD_WRITE_ENABLE = 1'b0;
    chk_ctl("load_use_after", 9'b000000000);
    tick(0);
    set_load_use(5'd0);
    chk_ctl("load_use_x0", 9'b000000000);
    tick(0);
    idle_inputs();
    chk("count_after_load_use", STALL_CYCLES, exp_cnt);

    // Mul/div with DONE four cycles after START
    EX_MULDIV_VALID = 1'b1;
    chk_ctl("md_start", 9'b111100011);
    tick(1);
    for (int i = 1; i < 4; i++) begin
      chk_ctl("md_busy", 9'b111100010);
      tick(1);
    end
    MULDIV_DONE = 1'b1;
    chk_ctl("md_done_release", 9'b000000000);
    tick(0);
    EX_MULDIV_VALID = 1'b0; MULDIV_DONE = 1'b0;
    chk_ctl("md_back_idle", 9'b000000000);
    chk("md_count", STALL_CYCLES, exp_cnt);
    tick(0);

    // DONE arrives while MEM misses: HOLD, everything through MEM frozen
    EX_MULDIV_VALID = 1'b1;
    chk_ctl("hold_start", 9'b111100011);
    tick(1);
    chk_ctl("hold_busy", 9'b111100010);
    tick(1);
    MEM_ACCESS_VALID = 1'b1; D_CACHE_READY = 1'b0;
    chk_ctl("hold_dmiss_busy", 9'b111110000);
    tick(1);
    MULDIV_DONE = 1'b1;
    chk_ctl("hold_dmiss_done", 9'b111110000);
    tick(1);
    MULDIV_DONE = 1'b0;
    chk_ctl("hold_dmiss_hold", 9'b111110000);
    tick(1);
    D_CACHE_READY = 1'b1;
    chk_ctl("hold_release", 9'b000000000);
    tick(0);
    EX_MULDIV_VALID = 1'b0; MEM_ACCESS_VALID = 1'b0;
    chk_ctl("hold_idle", 9'b000000000);
    tick(0);

    // Start deferred by a D-miss, then DONE on the first BUSY cycle
    EX_MULDIV_VALID = 1'b1; MEM_ACCESS_VALID = 1'b1; D_CACHE_READY = 1'b0;
    chk_ctl("start_blocked_dmiss", 9'b111110000);
    tick(1);
    D_CACHE_READY = 1'b1;
    chk_ctl("start_after_dmiss", 9'b111100011);
    tick(1);
    MULDIV_DONE = 1'b1; MEM_ACCESS_VALID = 1'b0;
    chk_ctl("done_n1", 9'b000000000);
    tick(0);
    idle_inputs();
    chk("count_after_md", STALL_CYCLES, exp_cnt);

    // Taken branch beats load-use and I-miss, but not a D-miss
    set_load_use(5'd7); I_CACHE_READY = 1'b0; BRANCH_TAKEN = 1'b1;
    chk_ctl("branch_override", 9'b000001100);
    tick(0);
    MEM_ACCESS_VALID = 1'b1; D_CACHE_READY = 1'b0;
    chk_ctl("branch_under_dmiss", 9'b111110000);
    tick(1);
    idle_inputs();
    I_CACHE_READY = 1'b0;
    chk_ctl("imiss_only", 9'b110001000);
    tick(1);
    idle_inputs();
    chk("count_after_branch", STALL_CYCLES, exp_cnt);

    // Reset in BUSY abandons the op; a late DONE is ignored
    EX_MULDIV_VALID = 1'b1;
    chk_ctl("rst_md_start", 9'b111100011);
    tick(1);
    chk_ctl("rst_md_busy", 9'b111100010);
    tick(1);
    RESET_N = 1'b0;
    chk_ctl("rst_md_reset", 9'b111111110);
    tick(0);
    exp_cnt = 0;
    RESET_N = 1'b1; EX_MULDIV_VALID = 1'b0; MULDIV_DONE = 1'b1;
    chk_ctl("rst_late_done", 9'b000000000);
    tick(0);
    EX_MULDIV_VALID = 1'b1; MULDIV_DONE = 1'b0;
    chk_ctl("rst_restart", 9'b111100011);
    tick(1);
    MULDIV_DONE = 1'b1;
    chk_ctl("rst_restart_done", 9'b000000000);
    tick(0);
    idle_inputs();
    chk("count_after_reset_md", STALL_CYCLES, exp_cnt);

    // 17 I-miss cycles wrap the 4-bit counter to 1
    RESET_N = 1'b0;
    tick(0);
    exp_cnt = 0;
    RESET_N = 1'b1;
    I_CACHE_READY = 1'b0;
    for (int i = 0; i < 17; i++) tick(1);
    I_CACHE_READY = 1'b1;
    #1;
    chk("wrap_w4", {28'd0, w4_cycles}, 32'd1);
    chk("wrap_w32", STALL_CYCLES, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
